// File: rtl/lowbit_find32_if.sv
// ----------------------------------------------------------------------------
// lowbit_find32_if
//   Request/result bundle for the lowest-set-bit search engine.
//
//   Signals
//     ld_i    start request; b_i is captured on every rising edge with ld_i=1
//     b_i     32-bit word to search
//     busy_o  high while a search is in progress
//     done_o  one-cycle pulse when idx_o/zero_o carry a fresh result
//     idx_o   index of the lowest set bit of the captured word
//     zero_o  high when the captured word was all zeros
//
//   Modports
//     master  requester side (drives ld_i/b_i, observes the result)
//     slave   engine side    (observes ld_i/b_i, drives the result)
// ----------------------------------------------------------------------------
interface lowbit_find32_if;
  logic        ld_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  idx_o;
  logic        zero_o;

  modport master (
    output ld_i,
    output b_i,
    input  busy_o,
    input  done_o,
    input  idx_o,
    input  zero_o
  );

  modport slave (
    input  ld_i,
    input  b_i,
    output busy_o,
    output done_o,
    output idx_o,
    output zero_o
  );
endinterface : lowbit_find32_if

// File: rtl/lowbit_find32.sv
// ----------------------------------------------------------------------------
// lowbit_find32
//   Multi-cycle search for the lowest set bit of a 32-bit word. The captured
//   word is walked from bit 0 upward in chunks of STEP bits, one chunk per
//   clock. The first chunk with any bit set yields the result; an all-zero
//   word reports idx_o=31 with zero_o=1. This is the inverse of the prefix-OR
//   used for sticky-bit generation.
//
//   Parameters
//     STEP    bits examined per scan cycle: 1, 2, 4, 8, 16 or 32
//
//   Ports
//     clk_i   system clock, rising edge
//     rst_i   asynchronous, active-high reset
//     bus     lowbit_find32_if.slave (ld_i, b_i in; busy_o, done_o, idx_o,
//             zero_o out)
//
//   Timing
//     A word loaded on edge E0 whose lowest set bit lies in chunk k shows
//     done_o in the cycle after edge E(k+1), i.e. it is sampled high on edge
//     E(k+2). busy_o covers the k+1 SCAN cycles before that. A new ld_i in
//     SCAN or DONE restarts the search; the old search never reports.
//     All outputs come straight from flops.
// ----------------------------------------------------------------------------
module lowbit_find32 #(
  parameter int STEP = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  lowbit_find32_if.slave bus
);

  localparam int         NCHUNK = 32 / STEP;
  localparam logic [4:0] K_LAST = 5'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [31:0]       word_q,  word_n;
  logic [4:0]        k_q,     k_n;
  logic [4:0]        idx_q,   idx_n;
  logic              zero_q,  zero_n;
  logic              busy_q,  busy_n;
  logic              done_q,  done_n;

  // Chunk currently under examination and its lowest set position.
  logic [STEP-1:0]   chunk;
  logic              hit;
  logic [4:0]        pos;

  // --------------------------------------------------------------------------
  // Chunk select and in-chunk priority encoder
  // --------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    chunk = STEP'(word_q >> (int'(k_q) * STEP));
    hit   = |chunk;
    pos   = '0;
    // Walking from the top down lets the lowest set bit overwrite last.
    for (int i = STEP - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        pos = 5'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    word_n  = word_q;
    k_n     = k_q;
    idx_n   = idx_q;
    zero_n  = zero_q;

    if (bus.ld_i) begin
      // A load wins in every state: it also aborts a search in flight, so
      // that search can never reach DONE.
      word_n  = bus.b_i;
      k_n     = '0;
      state_n = SCAN;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n = IDLE;
        end
        SCAN: begin
          if (hit) begin
            idx_n   = 5'(int'(k_q) * STEP) + pos;
            zero_n  = 1'b0;
            state_n = DONE;
          end else if (k_q == K_LAST) begin
            idx_n   = 5'd31;
            zero_n  = 1'b1;
            state_n = DONE;
          end else begin
            k_n     = k_q + 5'd1;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    // Status flags are registered copies of the next state, so busy_o and
    // done_o line up exactly with the SCAN and DONE cycles.
    busy_n = (state_n == SCAN);
    done_n = (state_n == DONE);
  end

  // --------------------------------------------------------------------------
  // State and result registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      word_q  <= word_n;
      k_q     <= k_n;
      idx_q   <= idx_n;
      zero_q  <= zero_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.idx_o  = idx_q;
  assign bus.zero_o = zero_q;

endmodule : lowbit_find32

// File: tb/tb_lowbit_find32.sv
// ----------------------------------------------------------------------------
// tb_lowbit_find32
//   Self-checking bench for lowbit_find32. Two instances run side by side:
//   STEP=8 and STEP=1. Expected results come from a behavioural model that
//   isolates the lowest set bit arithmetically and derives latency from the
//   chunk that bit falls in.
// ----------------------------------------------------------------------------
module tb_lowbit_find32;

  logic clk;
  logic rst;

  lowbit_find32_if bus8 ();
  lowbit_find32_if bus1 ();

  lowbit_find32 #(.STEP(8)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8.slave)
  );

  lowbit_find32 #(.STEP(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic ld, input logic [31:0] b);
    if (sel) begin
      bus1.ld_i = ld;
      bus1.b_i  = b;
    end else begin
      bus8.ld_i = ld;
      bus8.b_i  = b;
    end
  endtask

  task automatic peek(input bit sel, output logic busy, output logic done,
                      output logic [4:0] idx, output logic zero);
    if (sel) begin
      busy = bus1.busy_o; done = bus1.done_o; idx = bus1.idx_o; zero = bus1.zero_o;
    end else begin
      busy = bus8.busy_o; done = bus8.done_o; idx = bus8.idx_o; zero = bus8.zero_o;
    end
  endtask

  // Presents ld_i=1 for exactly one rising edge; returns just after it.
  task automatic load(input bit sel, input logic [31:0] b);
    @(negedge clk);
    drive(sel, 1'b1, b);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 32'h0);
  endtask

  // Counts falling edges after the load edge until done_o is seen.
  task automatic measure(input bit sel, output int lat, output int busy_cnt,
                         output logic [4:0] idx, output logic zero);
    logic b, d, z;
    logic [4:0] ix;
    lat = -1; busy_cnt = 0; idx = 'x; zero = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      peek(sel, b, d, ix, z);
      if (b) busy_cnt++;
      if (d) begin
        lat = n; idx = ix; zero = z;
        break;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic int ref_idx(input logic [31:0] b);
    logic [31:0] iso;
    if (b == 32'h0) return 31;
    iso = b & (~b + 32'd1);   // isolate the lowest set bit
    return $clog2(iso);
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input int step);
    if (b == 32'h0) return 32 / step + 1;
    return ref_idx(b) / step + 2;
  endfunction

  // Prefix-OR property: bits up to idx contain a 1, bits below idx do not.
  function automatic bit prop_ok(input logic [31:0] b, input logic [4:0] idx,
                                 input logic zero);
    logic [63:0] bw, m_hi, m_lo;
    bw = {32'h0, b};
    if (b == 32'h0) return (zero === 1'b1) && (idx === 5'd31);
    m_hi = (64'd2 << idx) - 64'd1;
    m_lo = (64'd1 << idx) - 64'd1;
    return (zero === 1'b0) && ((bw & m_hi) != 0) && ((bw & m_lo) == 0);
  endfunction

  typedef struct {
    logic [31:0] word;
    bit          sel;       // 0: STEP=8 instance, 1: STEP=1 instance
    int          exp_idx;
    bit          exp_zero;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin : main
    logic b, d, z;
    logic [4:0] ix;
    int lat, bc, bad;
    logic [31:0] w, r;
    int sh;

    vecs[0] = '{32'h0000_0001, 1'b0,  0, 1'b0,  2,  1};
    vecs[1] = '{32'h8000_0000, 1'b0, 31, 1'b0,  5,  4};
    vecs[2] = '{32'h0000_0000, 1'b0, 31, 1'b1,  5,  4};
    vecs[3] = '{32'h00F0_0100, 1'b0,  8, 1'b0,  3,  2};
    vecs[4] = '{32'h00F0_0100, 1'b1,  8, 1'b0, 10,  9};
    vecs[5] = '{32'h0001_0000, 1'b0, 16, 1'b0,  4,  3};
    vecs[6] = '{32'hFFFF_FFFF, 1'b0,  0, 1'b0,  2,  1};
    vecs[7] = '{32'h0000_0001, 1'b1,  0, 1'b0,  2,  1};
    vecs[8] = '{32'h0000_0000, 1'b1, 31, 1'b1, 33, 32};
    vecs[9] = '{32'h8000_0000, 1'b1, 31, 1'b0, 33, 32};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    #3;
    for (int s = 0; s < 2; s++) begin
      peek(s[0], b, d, ix, z);
      check($sformatf("reset_outputs_s%0d", s), {b, d, ix, z}, 8'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      load(vecs[i].sel, vecs[i].word);
      measure(vecs[i].sel, lat, bc, ix, z);
      check($sformatf("vec%0d_latency", i), lat,  vecs[i].exp_lat);
      check($sformatf("vec%0d_idx", i),     ix,   vecs[i].exp_idx);
      check($sformatf("vec%0d_zero", i),    z,    vecs[i].exp_zero);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      @(negedge clk);
      peek(vecs[i].sel, b, d, ix, z);
      check($sformatf("vec%0d_idle_after", i), {b, d}, 2'b00);
      check($sformatf("vec%0d_idx_held", i),   ix, vecs[i].exp_idx);
    end

    // Abort: second load two clocks after the first; only it reports.
    load(1'b0, 32'h8000_0000);
    @(negedge clk);
    peek(1'b0, b, d, ix, z);
    check("abort_no_early_done", d, 1'b0);
    load(1'b0, 32'h0000_0004);
    measure(1'b0, lat, bc, ix, z);
    check("abort_latency", lat, 2);
    check("abort_idx", ix, 2);
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      peek(1'b0, b, d, ix, z);
      if (d) bad++;
    end
    check("abort_no_stale_done", bad, 0);

    // Load coinciding with DONE: old result still shows, new search follows.
    load(1'b0, 32'h0000_0001);
    @(negedge clk);
    @(negedge clk);
    peek(1'b0, b, d, ix, z);
    check("coincide_done_old", {d, ix}, {1'b1, 5'd0});
    drive(1'b0, 1'b1, 32'h00F0_0100);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0);
    peek(1'b0, b, d, ix, z);
    check("coincide_scan_next", {b, d}, 2'b10);
    measure(1'b0, lat, bc, ix, z);
    check("coincide_new_latency", lat, 3);
    check("coincide_new_idx", ix, 8);

    // Asynchronous reset mid-SCAN, with ld_i pulsed while reset is held.
    load(1'b0, 32'h8000_0000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    peek(1'b0, b, d, ix, z);
    check("async_reset_outputs", {b, d, ix, z}, 8'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0001);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      peek(1'b0, b, d, ix, z);
      if (b || d) bad++;
    end
    check("reset_release_quiet", bad, 0);

    // Random words, biased so every chunk and the all-zero case get hit.
    for (int t = 0; t < 10000; t++) begin
      r  = $urandom;
      sh = $urandom_range(0, 32);
      w  = (sh == 32) ? 32'h0 : (r & (32'hFFFF_FFFF << sh));
      load(1'b0, w);
      measure(1'b0, lat, bc, ix, z);
      check($sformatf("rnd8_%0d_idx w=%h", t, w), ix, ref_idx(w));
      check($sformatf("rnd8_%0d_zero w=%h", t, w), z, (w == 32'h0));
      check($sformatf("rnd8_%0d_latency w=%h", t, w), lat, ref_lat(w, 8));
      check($sformatf("rnd8_%0d_prefix_or w=%h", t, w), prop_ok(w, ix, z), 1'b1);
    end

    for (int t = 0; t < 300; t++) begin
      r  = $urandom;
      sh = $urandom_range(0, 32);
      w  = (sh == 32) ? 32'h0 : (r & (32'hFFFF_FFFF << sh));
      load(1'b1, w);
      measure(1'b1, lat, bc, ix, z);
      check($sformatf("rnd1_%0d_idx w=%h", t, w), ix, ref_idx(w));
      check($sformatf("rnd1_%0d_latency w=%h", t, w), lat, ref_lat(w, 1));
      check($sformatf("rnd1_%0d_prefix_or w=%h", t, w), prop_ok(w, ix, z), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lowbit_find32

// File: doc/lowbit_find32.md
LOWBIT_FIND32 -- requirements
Module: lowbit_find32

Interface
REQ-001 SHALL have parameter STEP, default 8, meaning bits examined per scan cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have port clk_i  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ld_i  input  1  start request; b_i is captured on any rising edge where ld_i=1.
REQ-005 SHALL have port b_i  input  32  word to search; sampled only when ld_i=1.
REQ-006 SHALL have port busy_o  output  1  high while a search is in progress.
REQ-007 SHALL have port done_o  output  1  one-cycle pulse when results become valid.
REQ-008 SHALL have port idx_o  output  5  index of the lowest set bit of the captured word.
REQ-009 SHALL have port zero_o  output  1  high when the captured word was all zeros.

Function
REQ-010 SHALL compute idx_o so that, for a nonzero word b, |b[idx_o:0]=1 and either idx_o=0 or |b[idx_o-1:0]=0; this is the inverse of the prefix-OR function used for sticky-bit generation.
REQ-011 SHALL implement the states IDLE, SCAN and DONE.
REQ-012 SHALL capture b_i into an internal register, clear the chunk counter k and enter SCAN on any edge with ld_i=1, from any state.
REQ-013 SHALL, in SCAN, examine chunk k, i.e. bits [k*STEP+STEP-1 : k*STEP], during one cycle.
REQ-014 SHALL, on a hit in chunk k, set idx_o = k*STEP + (lowest set position within the chunk), set zero_o=0 and enter DONE.
REQ-015 SHALL, on a miss in chunk k below the last chunk (32/STEP-1), increment k and remain in SCAN.
REQ-016 SHALL, on a miss in the last chunk, set idx_o=31, set zero_o=1 and enter DONE.
REQ-017 SHALL assert done_o for exactly the one cycle spent in DONE, then return to IDLE with done_o=0.
REQ-018 SHALL assert done_o k+2 clocks after the edge that sampled ld_i, where k is the hit chunk; for an all-zero word, the latency SHALL be 32/STEP+1 clocks.
REQ-019 SHALL assert busy_o in SCAN and deassert it in IDLE and DONE.
REQ-020 SHALL hold idx_o and zero_o stable from done_o until the next result is registered.
REQ-021 SHALL abort a search in progress when ld_i=1 arrives in SCAN or DONE, and restart it with the new b_i.
REQ-022 SHALL NOT emit done_o for an aborted search.
REQ-023 SHALL, when ld_i=1 coincides with DONE, still show done_o=1 for that DONE cycle (old result) and enter SCAN on the next edge.
REQ-024 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, while rst_i=1, immediately force state IDLE, busy_o=0, done_o=0, idx_o=0, zero_o=0, k=0 and the captured word to 0, regardless of clk_i.
REQ-026 SHALL cancel any search on reset mid-operation, and SHALL NOT pulse done_o after reset release until a new ld_i.
REQ-027 SHALL ignore ld_i while rst_i=1.

Verification (STEP=8 unless noted)
REQ-028 SHALL cover: ld b_i=0x00000001 -> done_o 2 clocks later, idx_o=0, zero_o=0, busy_o high for 1 cycle.
REQ-029 SHALL cover: ld b_i=0x80000000 -> done_o 5 clocks later, idx_o=31, zero_o=0; ld b_i=0x00000000 -> done_o 5 clocks later, idx_o=31, zero_o=1.
REQ-030 SHALL cover: ld b_i=0x00F00100 -> done_o 3 clocks later, idx_o=8; with STEP=1, the same word -> done_o 10 clocks later, idx_o=8.
REQ-031 SHALL cover: ld 0x80000000, then ld 0x00000004 two clocks later -> a single done_o 2 clocks after the second ld, idx_o=2; no done_o for the first search.
REQ-032 SHALL cover: rst_i asserted asynchronously mid-SCAN -> all outputs 0 immediately, and no done_o for 10 clocks after release.
REQ-033 SHALL cover: 10000 random words, each result checked against the prefix-OR property of REQ-010 and the latency rule of REQ-018.
